maxpool_s2_stream: RTL and testbench

//  Streaming 2x2/stride-2 max-pool stage directly downstream of the first conv layer.
//  - Consumes the conv layer's post-ReLU FP32 output stream: one value per valid cycle, raster order,
//    one feature map after another.
//  - Writes pooled maps into the next layer's IFM memories (address + per-map write-enable one-hot).
//  - Pulses done after NUMBER_OF_FILTERS maps.

---
 rtl/maxpool_s2_stream_pkg.sv | 15 +
 rtl/maxpool_s2_stream_fp32_max.sv | 39 +++
 rtl/maxpool_s2_stream.sv | 184 ++++++++++++++++++
 tb/tb_maxpool_s2_stream.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_s2_stream_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool stage.
//   Fp32Width / Fp32SignBit : FP32 word layout, common with the conv/FC stages.
//   pool_state_e            : frame-level FSM states.
package maxpool_s2_stream_pkg;

  localparam int unsigned Fp32Width   = 32;
  localparam int unsigned Fp32SignBit = 31;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } pool_state_e;

endpackage

// File: rtl/maxpool_s2_stream_fp32_max.sv
// Combinational FP32 max on the sign/magnitude total order (NaN not handled).
//   a : first (earlier) operand, wins every tie, including +0 vs -0
//   b : second operand
//   y : the larger of a and b
module maxpool_s2_stream_fp32_max
  import maxpool_s2_stream_pkg::*;
(
  input  logic [Fp32Width-1:0] a,
  input  logic [Fp32Width-1:0] b,
  output logic [Fp32Width-1:0] y
);

  logic                   a_neg, b_neg;
  logic [Fp32SignBit-1:0] a_mag, b_mag;
  logic                   a_wins;

  assign a_neg = a[Fp32SignBit];
  assign b_neg = b[Fp32SignBit];
  assign a_mag = a[Fp32SignBit-1:0];
  assign b_mag = b[Fp32SignBit-1:0];

  always_comb begin
    a_wins = 1'b1;
    if ((a_mag == '0) && (b_mag == '0)) begin
      // +0 and -0 compare equal, so the earlier operand keeps its sign.
      a_wins = 1'b1;
    end else if (a_neg != b_neg) begin
      a_wins = !a_neg;
    end else if (!a_neg) begin
      a_wins = (a_mag >= b_mag);
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      a_wins = (a_mag <= b_mag);
    end
  end

  assign y = a_wins ? a : b;

endmodule

// File: rtl/maxpool_s2_stream.sv
// Streaming 2x2/stride-2 max-pool stage behind the first conv layer.
// Consumes post-ReLU FP32 pixels in raster order, one map after another, and writes each pooled
// value into the next layer's IFM memory one cycle after the pixel that completes its window.
//   clk, reset (async, active low)
//   start       : 1-cycle pulse, arms a new frame from IDLE
//   in_valid    : data_in carries a conv pixel
//   data_in     : conv pixel (FP32)
//   out_data    : pooled value
//   out_address : row*OFM_SIZE+col inside the current map
//   out_we      : one-hot write enable of the target map
//   busy        : frame in progress
//   done        : pulses together with the final write of the frame
module maxpool_s2_stream
  import maxpool_s2_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = Fp32Width,
  parameter int unsigned IFM_SIZE          = 28,
  parameter int unsigned NUMBER_OF_FILTERS = 6,
  parameter int unsigned OFM_SIZE          = IFM_SIZE / 2,
  parameter int unsigned ADDRESS_SIZE_OFM  = $clog2(OFM_SIZE * OFM_SIZE),
  parameter int unsigned SEL_BITS          = $clog2(NUMBER_OF_FILTERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [ADDRESS_SIZE_OFM-1:0]  out_address,
  output logic [NUMBER_OF_FILTERS-1:0] out_we,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned ColW  = $clog2(IFM_SIZE);
  localparam int unsigned HalfW = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
  // A single-map build still needs a 1-bit map counter.
  localparam int unsigned MapW  = (SEL_BITS > 0) ? SEL_BITS : 1;

  localparam logic [ColW-1:0] PixLast = ColW'(IFM_SIZE - 1);
  localparam logic [MapW-1:0] MapLast = MapW'(NUMBER_OF_FILTERS - 1);

  if ((IFM_SIZE % 2) != 0) begin : g_odd_ifm
    $error("maxpool_s2_stream: IFM_SIZE must be even");
  end
  if (DATA_WIDTH != Fp32Width) begin : g_bad_width
    $error("maxpool_s2_stream: DATA_WIDTH must be 32 (FP32)");
  end

  pool_state_e                  state_q, state_d;
  logic [ColW-1:0]              col_q, col_d, row_q, row_d;
  logic [MapW-1:0]              map_q, map_d;
  logic [DATA_WIDTH-1:0]        h_q, h_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic [ADDRESS_SIZE_OFM-1:0]  out_address_q, out_address_d;
  logic [NUMBER_OF_FILTERS-1:0] out_we_q, out_we_d;
  logic                         done_q, done_d;
  // Low for the first edge after reset release so a start there is ignored.
  logic                         armed_q;

  logic [DATA_WIDTH-1:0] row_buf_q [OFM_SIZE];
  logic                  buf_we;
  logic [HalfW-1:0]      half_col;
  logic [DATA_WIDTH-1:0] h_max, v_max;
  logic                  last_col, last_row, last_map;

  assign half_col = HalfW'(col_q >> 1);
  assign last_col = (col_q == PixLast);
  assign last_row = (row_q == PixLast);
  assign last_map = (map_q == MapLast);

  maxpool_s2_stream_fp32_max u_h_max (
    .a (h_q),
    .b (data_in),
    .y (h_max)
  );

  maxpool_s2_stream_fp32_max u_v_max (
    .a (row_buf_q[half_col]),
    .b (h_max),
    .y (v_max)
  );

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    map_d         = map_q;
    h_d           = h_q;
    out_data_d    = out_data_q;
    out_address_d = out_address_q;
    out_we_d      = '0;
    done_d        = 1'b0;
    buf_we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && armed_q) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
          map_d   = '0;
        end
      end
      StRun: begin
        if (in_valid) begin
          if (!col_q[0]) begin
            h_d = data_in;
          end else if (!row_q[0]) begin
            buf_we = 1'b1;
          end else begin
            out_data_d    = v_max;
            out_address_d = ADDRESS_SIZE_OFM'(row_q >> 1) * ADDRESS_SIZE_OFM'(OFM_SIZE)
                          + ADDRESS_SIZE_OFM'(half_col);
            out_we_d      = NUMBER_OF_FILTERS'(1) << map_q;
          end

          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d = '0;
              map_d = last_map ? '0 : map_q + MapW'(1);
            end else begin
              row_d = row_q + ColW'(1);
            end
          end else begin
            col_d = col_q + ColW'(1);
          end

          if (last_col && last_row && last_map) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      col_q         <= '0;
      row_q         <= '0;
      map_q         <= '0;
      h_q           <= '0;
      out_data_q    <= '0;
      out_address_q <= '0;
      out_we_q      <= '0;
      done_q        <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      map_q         <= map_d;
      h_q           <= h_d;
      out_data_q    <= out_data_d;
      out_address_q <= out_address_d;
      out_we_q      <= out_we_d;
      done_q        <= done_d;
      armed_q       <= 1'b1;
    end
  end

  // Row buffer is always rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      row_buf_q[half_col] <= h_max;
    end
  end

  assign out_data    = out_data_q;
  assign out_address = out_address_q;
  assign out_we      = out_we_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;

endmodule

// File: tb/tb_maxpool_s2_stream.sv
module tb_maxpool_s2_stream;

  localparam int unsigned SIfm  = 4;
  localparam int unsigned SMaps = 1;
  localparam int unsigned BIfm  = 28;
  localparam int unsigned BMaps = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        s_start, s_valid, s_busy, s_done;
  logic [31:0] s_data, s_out_data;
  logic [1:0]  s_out_addr;
  logic [0:0]  s_out_we;
  logic        b_start, b_valid, b_busy, b_done;
  logic [31:0] b_data, b_out_data;
  logic [7:0]  b_out_addr;
  logic [5:0]  b_out_we;

  maxpool_s2_stream #(
    .DATA_WIDTH        (32),
    .IFM_SIZE          (SIfm),
    .NUMBER_OF_FILTERS (SMaps)
  ) u_small (
    .clk         (clk),
    .reset       (reset),
    .start       (s_start),
    .in_valid    (s_valid),
    .data_in     (s_data),
    .out_data    (s_out_data),
    .out_address (s_out_addr),
    .out_we      (s_out_we),
    .busy        (s_busy),
    .done        (s_done)
  );

  maxpool_s2_stream #(
    .DATA_WIDTH        (32),
    .IFM_SIZE          (BIfm),
    .NUMBER_OF_FILTERS (BMaps)
  ) u_big (
    .clk         (clk),
    .reset       (reset),
    .start       (b_start),
    .in_valid    (b_valid),
    .data_in     (b_data),
    .out_data    (b_out_data),
    .out_address (b_out_addr),
    .out_we      (b_out_we),
    .busy        (b_busy),
    .done        (b_done)
  );

  typedef struct {
    int unsigned cyc;
    logic [5:0]  we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] w[4];
    logic [31:0] want;
  } win_vec_t;

  wr_t         s_got[$], b_got[$], exp_q[$];
  logic [31:0] px[$];
  int unsigned pcyc[$];
  win_vec_t    vecs[7];
  int          checks = 0;
  int          errors = 0;

  // Record every cycle that carries a write strobe or done.
  always @(negedge clk) begin
    if ((s_out_we != '0) || s_done)
      s_got.push_back('{cyc: cyc, we: 6'(s_out_we), addr: 8'(s_out_addr), data: s_out_data,
                        done: s_done});
    if ((b_out_we != '0) || b_done)
      b_got.push_back('{cyc: cyc, we: b_out_we, addr: b_out_addr, data: b_out_data,
                        done: b_done});
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    px.delete();
    pcyc.delete();
    exp_q.delete();
    s_got.delete();
    b_got.delete();
  endtask

  task automatic pulse_start(input bit big);
    if (big) b_start = 1'b1;
    else s_start = 1'b1;
    tick();
    b_start = 1'b0;
    s_start = 1'b0;
  endtask

  // One valid cycle, then gap idle cycles with garbage on the data bus.
  task automatic send(input bit big, input logic [31:0] d, input int unsigned gap, input bit rec);
    if (rec) begin
      px.push_back(d);
      pcyc.push_back(cyc);
    end
    if (big) begin
      b_valid = 1'b1;
      b_data  = d;
    end else begin
      s_valid = 1'b1;
      s_data  = d;
    end
    tick();
    b_valid = 1'b0;
    s_valid = 1'b0;
    s_data  = $urandom;
    b_data  = $urandom;
    repeat (gap) tick();
  endtask

  function automatic logic [31:0] int_to_fp(input int unsigned n);
    int unsigned e;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h007F_FFFF)};
  endfunction

  function automatic logic [31:0] rnd_px();
    logic [31:0] pool[6];
    pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,
             32'h0000_0001};
    case ($urandom_range(0, 2))
      0:       return pool[$urandom_range(0, 5)];
      1:       return {1'b0, 31'($urandom_range(0, 32'h7F7F_FFFF))};
      default: return {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h7F7F_FFFF))};
    endcase
  endfunction

  // Map each FP32 pattern onto a signed integer line: +0 and -0 both land on 0.
  function automatic longint fkey(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  // Expected writes for the frame held in px/pcyc: earliest pixel holding the largest value wins.
  task automatic build_exp(input int unsigned ifm, input int unsigned maps);
    int unsigned ofm, i0;
    logic [31:0] w[4];
    logic [31:0] best;
    wr_t         e;
    ofm = ifm / 2;
    for (int unsigned k = 0; k < maps; k++) begin
      for (int unsigned r = 0; r < ofm; r++) begin
        for (int unsigned c = 0; c < ofm; c++) begin
          i0   = k * ifm * ifm + 2 * r * ifm + 2 * c;
          w    = '{px[i0], px[i0 + 1], px[i0 + ifm], px[i0 + ifm + 1]};
          best = w[0];
          for (int j = 1; j < 4; j++) if (fkey(w[j]) > fkey(best)) best = w[j];
          e.cyc  = pcyc[i0 + ifm + 1] + 1;
          e.we   = 6'(1 << k);
          e.addr = 8'(r * ofm + c);
          e.data = best;
          e.done = (k == maps - 1) && (r == ofm - 1) && (c == ofm - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic cmp_frame(input string nm, input bit big);
    wr_t got[$];
    if (big) got = b_got;
    else got = s_got;
    chk({nm, " write count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s[%0d] cycle", nm, i), 64'(got[i].cyc), 64'(exp_q[i].cyc));
      chk($sformatf("%s[%0d] we", nm, i), 64'(got[i].we), 64'(exp_q[i].we));
      chk($sformatf("%s[%0d] addr", nm, i), 64'(got[i].addr), 64'(exp_q[i].addr));
      chk($sformatf("%s[%0d] data", nm, i), 64'(got[i].data), 64'(exp_q[i].data));
      chk($sformatf("%s[%0d] done", nm, i), 64'(got[i].done), 64'(exp_q[i].done));
    end
    clear_all();
  endtask

  task automatic set_vec(input int idx, input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] want);
    vecs[idx].name = name;
    vecs[idx].w    = '{a, b, c, d};
    vecs[idx].want = want;
  endtask

  initial begin
    logic [31:0] ramp_want[4];
    ramp_want = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};

    set_vec(0, "neg", 32'hC000_0000, 32'hBF00_0000, 32'hC040_0000, 32'hBF80_0000, 32'hBF00_0000);
    set_vec(1, "zeros", 32'h0000_0000, 32'h8000_0000, 32'hBF80_0000, 32'h8000_0000, 32'h0000_0000);
    set_vec(2, "negzero_first", 32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hBF80_0000,
            32'h8000_0000);
    set_vec(3, "ascending", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
            32'h4080_0000);
    set_vec(4, "mixed", 32'h40A0_0000, 32'hC0A0_0000, 32'h0000_0000, 32'h3F80_0000,
            32'h40A0_0000);
    set_vec(5, "denorm", 32'hBF80_0000, 32'h0000_0001, 32'h8000_0000, 32'hC000_0000,
            32'h0000_0001);
    set_vec(6, "neg_tie_bottom", 32'hC000_0000, 32'hC040_0000, 32'hBF80_0000, 32'hBF80_0000,
            32'hBF80_0000);

    reset   = 1'b0;
    s_start = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    b_start = 1'b0;
    b_valid = 1'b0;
    b_data  = '0;
    repeat (3) tick();

    chk("reset s out_data", 64'(s_out_data), 0);
    chk("reset s out_address", 64'(s_out_addr), 0);
    chk("reset s out_we", 64'(s_out_we), 0);
    chk("reset s busy", 64'(s_busy), 0);
    chk("reset s done", 64'(s_done), 0);
    chk("reset b out_data", 64'(b_out_data), 0);
    chk("reset b out_address", 64'(b_out_addr), 0);
    chk("reset b out_we", 64'(b_out_we), 0);
    chk("reset b busy", 64'(b_busy), 0);

    // start on the first edge after reset release must not arm the frame
    reset   = 1'b1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("start at reset release ignored", 64'(s_busy), 0);
    repeat (2) tick();
    clear_all();

    // Window vectors: the same 2x2 tuple is replicated into every window of a 4x4 map.
    for (int v = 0; v < 7; v++) begin
      pulse_start(0);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) send(0, vecs[v].w[(r % 2) * 2 + (c % 2)], 0, 1);
      repeat (3) tick();
      chk({vecs[v].name, " write count"}, 64'(s_got.size()), 4);
      for (int i = 0; i < 4 && i < s_got.size(); i++) begin
        chk($sformatf("%s[%0d] data", vecs[v].name, i), 64'(s_got[i].data), 64'(vecs[v].want));
        chk($sformatf("%s[%0d] addr", vecs[v].name, i), 64'(s_got[i].addr), 64'(i));
        chk($sformatf("%s[%0d] done", vecs[v].name, i), 64'(s_got[i].done), 64'(i == 3));
      end
      clear_all();
    end

    // Ramp 1.0..16.0, back-to-back and then with random gaps.
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start(0);
      chk($sformatf("ramp%0d busy in run", pass), 64'(s_busy), 1);
      for (int n = 1; n <= 16; n++)
        send(0, int_to_fp(n), (pass == 0) ? 0 : $urandom_range(0, 5), 1);
      repeat (3) tick();
      chk($sformatf("ramp%0d busy after done", pass), 64'(s_busy), 0);
      for (int i = 0; i < 4 && i < s_got.size(); i++)
        chk($sformatf("ramp%0d[%0d] value", pass, i), 64'(s_got[i].data), 64'(ramp_want[i]));
      build_exp(SIfm, SMaps);
      cmp_frame($sformatf("ramp%0d", pass), 0);
    end

    // Pixels while idle are ignored; a start pulse mid-frame is ignored.
    for (int f = 0; f < 12; f++) begin
      if (f == 0) begin
        for (int i = 0; i < 3; i++) send(0, rnd_px(), 0, 0);
        chk("idle pixels make no write", 64'(s_got.size()), 0);
        chk("idle pixels keep busy low", 64'(s_busy), 0);
      end
      pulse_start(0);
      for (int i = 0; i < 16; i++) begin
        send(0, rnd_px(), $urandom_range(0, 5), 1);
        if (i == 7 && (f % 2) == 1) pulse_start(0);
      end
      repeat (3) tick();
      build_exp(SIfm, SMaps);
      cmp_frame($sformatf("rand_small%0d", f), 0);
    end

    // Reset mid-frame at pixel 100 of the default-size instance.
    pulse_start(1);
    for (int i = 0; i < 100; i++) send(1, rnd_px(), 0, 0);
    chk("pre-reset write strobe", 64'(b_out_we), 1);
    reset = 1'b0;
    #1;
    chk("mid reset out_data", 64'(b_out_data), 0);
    chk("mid reset out_address", 64'(b_out_addr), 0);
    chk("mid reset out_we", 64'(b_out_we), 0);
    chk("mid reset busy", 64'(b_busy), 0);
    chk("mid reset done", 64'(b_done), 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    clear_all();
    for (int i = 0; i < BIfm * BIfm; i++) send(1, rnd_px(), 0, 0);
    repeat (3) tick();
    chk("no writes without start", 64'(b_got.size()), 0);
    chk("busy low without start", 64'(b_busy), 0);

    // Constant k+1.0 per map k.
    clear_all();
    pulse_start(1);
    for (int k = 0; k < BMaps; k++)
      for (int i = 0; i < BIfm * BIfm; i++) send(1, int_to_fp(k + 1), 0, 1);
    repeat (3) tick();
    chk("const frame busy after done", 64'(b_busy), 0);
    build_exp(BIfm, BMaps);
    cmp_frame("const_big", 1);

    // Random data with gaps and a stray start mid-frame.
    pulse_start(1);
    for (int i = 0; i < BIfm * BIfm * BMaps; i++) begin
      send(1, rnd_px(), $urandom_range(0, 2), 1);
      if (i == 2000) pulse_start(1);
    end
    repeat (3) tick();
    build_exp(BIfm, BMaps);
    cmp_frame("rand_big", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
